adder_sum_fifo: RTL and testbench

- Downstream stage of the ripple-carry adder model.
- Captures each (DATA_WIDTH+1)-bit sum into a small flip-flop-array FIFO under a valid/ready handshake.
- Presents stored sums in order to the consumer and tracks carry-out (overflow) events.
- Decouples adder timing from the consumer and gives a registered, buffered result path.

---
 rtl/adder_sum_fifo.sv | 115 +++++++++++
 tb/tb_adder_sum_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_fifo.sv
// Small flip-flop FIFO behind the ripple-carry adder: buffers (DATA_WIDTH+1)-bit
// sums under valid/ready, presents them first-word fall-through, and tracks carry-out events.
module adder_sum_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH:0]      in_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH:0]      out_sum,
  output logic                     out_carry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     carry_seen,
  output logic [CNT_W-1:0]         carry_cnt,
  input  logic                     clr_carry
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic                  push;
  logic                  pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Control state, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (push && !pop && count == CW'(DEPTH - 1))
          state_d = ST_FULL;
        else if (pop && !push && count == CW'(1))
          state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (pop) state_d = ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    empty     = 1'b0;
    full      = 1'b0;
    empty     = (state_q == ST_EMPTY);
    full      = (state_q == ST_FULL);
    in_ready  = !full;
    out_valid = !empty;
  end

  // Storage is data-only; its contents are meaningless while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_sum;
  end

  assign out_sum   = mem[rd_ptr];
  assign out_carry = out_sum[DATA_WIDTH];

  // A carry push in the same cycle as a clear restarts the count at one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_seen <= 1'b0;
      carry_cnt  <= '0;
    end else if (push && in_sum[DATA_WIDTH]) begin
      carry_seen <= 1'b1;
      carry_cnt  <= clr_carry ? CNT_W'(1) : sat_inc(carry_cnt);
    end else if (clr_carry) begin
      carry_seen <= 1'b0;
      carry_cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_adder_sum_fifo.sv
// Bench for adder_sum_fifo: directed scenarios plus random traffic against a queue model.
module tb_adder_sum_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [DW:0]             in_sum = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [DW:0]             out_sum;
  logic                    out_carry;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;
  logic                    carry_seen;
  logic [CNT_W-1:0]        carry_cnt;
  logic                    clr_carry = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DW:0] m_q[$];
  int          m_cnt  = 0;
  bit          m_seen = 1'b0;

  adder_sum_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
    .count(count), .full(full), .empty(empty), .carry_seen(carry_seen),
    .carry_cnt(carry_cnt), .clr_carry(clr_carry)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(m_q.size()));
    chk({tag, "_full"}, 32'(full), 32'(m_q.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty), 32'(m_q.size() == 0));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(m_q.size() < DEPTH));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
    chk({tag, "_carry_seen"}, 32'(carry_seen), 32'(m_seen));
    chk({tag, "_carry_cnt"}, 32'(carry_cnt), 32'(m_cnt));
    if (m_q.size() > 0) begin
      chk({tag, "_out_sum"}, 32'(out_sum), 32'(m_q[0]));
      chk({tag, "_out_carry"}, 32'(out_carry), 32'(m_q[0][DW]));
    end
  endtask

  // One clock: model decides acceptance from the pre-edge occupancy, then compares on the falling edge.
  task automatic step(input string tag);
    bit          do_push;
    bit          do_pop;
    logic [DW:0] w;
    bit          clr;
    do_push = in_valid && (m_q.size() < DEPTH);
    do_pop  = out_ready && (m_q.size() > 0);
    w       = in_sum;
    clr     = clr_carry;
    @(posedge clk);
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(w);
    if (do_push && w[DW]) begin
      m_seen = 1'b1;
      m_cnt  = clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
    end else if (clr) begin
      m_seen = 1'b0;
      m_cnt  = 0;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_carry = 1'b0;
  endtask

  task automatic drain(input string tag);
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step(tag);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DW:0] vec3 [3];
    vec3[0] = 9'h006; vec3[1] = 9'h011; vec3[2] = 9'h138;

    // Reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all("reset");
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    step("idle");

    // Three adder results, then ordered pops
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sum   = vec3[i];
      step("push3");
    end
    in_valid = 1'b0;
    chk("push3_count", 32'(count), 32'd3);
    chk("push3_head", 32'(out_sum), 32'h006);
    chk("push3_seen", 32'(carry_seen), 32'd1);
    chk("push3_cnt", 32'(carry_cnt), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("pop3_sum", 32'(out_sum), 32'(vec3[i]));
      chk("pop3_carry", 32'(out_carry), (i == 2) ? 32'd1 : 32'd0);
      step("pop3");
    end
    chk("pop3_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Fill, then push against a full FIFO
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_sum   = 9'(i);
      step("fill");
    end
    in_sum = 9'd5;
    for (int i = 0; i < 3; i++) begin
      step("full_hold");
      chk("full_flag", 32'(full), 32'd1);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_count", 32'(count), 32'd4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("full_pop_sum", 32'(out_sum), 32'(i));
      step("full_pop");
    end
    chk("full_pop_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Pop while full must not admit a push that same cycle
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sum   = 9'(8'h20 + i);
      step("refill");
    end
    in_sum    = 9'h0ee;
    out_ready = 1'b1;
    step("full_pop_push");
    chk("full_pop_push_count", 32'(count), 32'd3);
    drain("drain1");

    // Streaming through with wrap-around
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_sum = 9'(8'h40 + i);
      step("stream");
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_head", 32'(out_sum), 32'(8'h40 + i));
    end
    drain("drain2");

    // Saturation of the carry counter, then clear coinciding with a carry push
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_sum = {1'b1, 8'($urandom)};
      step("sat");
    end
    chk("sat_cnt", 32'(carry_cnt), 32'd255);
    clr_carry = 1'b1;
    in_sum    = 9'h1ff;
    step("clr_set");
    chk("clr_set_cnt", 32'(carry_cnt), 32'd1);
    chk("clr_set_seen", 32'(carry_seen), 32'd1);
    in_valid = 1'b0;
    step("clr_only");
    chk("clr_only_cnt", 32'(carry_cnt), 32'd0);
    drain("drain3");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_carry = ($urandom_range(0, 15) == 0);
      in_sum    = 9'($urandom);
      step("rand");
    end
    drain("drain4");

    // Asynchronous reset mid-cycle discards stored words
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sum   = 9'(9'h150 + i);
      step("pre_rst");
    end
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_seen", 32'(carry_seen), 32'd0);
    m_q.delete();
    m_cnt  = 0;
    m_seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all("post_rst");
    in_valid = 1'b1;
    in_sum   = 9'h0aa;
    step("post_rst_push");
    in_valid = 1'b0;
    chk("post_rst_first", 32'(out_sum), 32'h0aa);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
